// File: rtl/dag_unit.sv
// -----------------------------------------------------------------------------
// dag_unit -- data address generator
//
// Produces the data-memory address for every DM access and owns the eight
// index/modify/length/base register sets (I0-I7, M0-M7, L0-L7, B0-B7).
// Addresses come out one cycle after the request, either pre-modified
// (I + M, index untouched) or post-modified (I, then the index advances by M
// with optional circular-buffer wrap inside [B, B+L)).
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   reset          synchronous, active-low reset
//   ps_dg_en       DM access this cycle, generate an address
//   ps_dg_premod   1 = pre-modify, 0 = post-modify
//   ps_dg_iadd     index register select
//   ps_dg_madd     modify register select
//   ps_dg_imm_en   use ps_dg_imm_mod instead of M[madd]
//   ps_dg_imm_mod  immediate modifier, two's complement
//   ps_dg_wrt_en   register write strobe
//   ps_dg_wrt_add  write select: [4:3] group (I/M/L/B), [2:0] register
//   bc_dg_dt       write data from the shared bus (low DMA_SIZE bits used)
//   ps_dg_rd_en    register read strobe
//   ps_dg_rd_add   read select, same encoding as ps_dg_wrt_add
//   dg_dm_add      registered DM address
//   dg_bc_dt       registered read data, zero-extended to the bus width
//
// DMA_SIZE must not exceed DMD_SIZE.
// -----------------------------------------------------------------------------
module dag_unit #(
  parameter int DMA_SIZE = 16,
  parameter int DMD_SIZE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_dg_en,
  input  logic                ps_dg_premod,
  input  logic [2:0]          ps_dg_iadd,
  input  logic [2:0]          ps_dg_madd,
  input  logic                ps_dg_imm_en,
  input  logic [DMA_SIZE-1:0] ps_dg_imm_mod,
  input  logic                ps_dg_wrt_en,
  input  logic [4:0]          ps_dg_wrt_add,
  input  logic [DMD_SIZE-1:0] bc_dg_dt,
  input  logic                ps_dg_rd_en,
  input  logic [4:0]          ps_dg_rd_add,
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic [DMD_SIZE-1:0] dg_bc_dt
);

  // Register group encoding shared by the write and read select fields.
  typedef enum logic [1:0] {
    GRP_I = 2'b00,
    GRP_M = 2'b01,
    GRP_L = 2'b10,
    GRP_B = 2'b11
  } reg_grp_e;

  typedef logic [DMA_SIZE-1:0] addr_t;
  typedef logic [DMA_SIZE:0]   addr_ext_t;

  addr_t i_reg [8];
  addr_t m_reg [8];
  addr_t l_reg [8];
  addr_t b_reg [8];

  // ---------------------------------------------------------------------------
  // Address datapath
  // ---------------------------------------------------------------------------
  addr_t     i_cur;
  addr_t     l_cur;
  addr_t     b_cur;
  addr_t     mv;
  logic      mv_neg;
  addr_t     lin_sum;
  addr_ext_t circ_sum;
  addr_ext_t circ_top;
  addr_t     next_i;

  always_comb begin
    i_cur   = i_reg[ps_dg_iadd];
    l_cur   = l_reg[ps_dg_iadd];
    b_cur   = b_reg[ps_dg_iadd];
    mv      = ps_dg_imm_en ? ps_dg_imm_mod : m_reg[ps_dg_madd];
    mv_neg  = mv[DMA_SIZE-1];
    lin_sum = i_cur + mv;

    // The circular sum carries one extra bit. Mv is sign-extended so a
    // negative step that stays above zero drops back into DMA_SIZE bits and
    // compares correctly against the buffer base.
    circ_sum = {1'b0, i_cur} + {mv_neg, mv};
    circ_top = {1'b0, b_cur} + {1'b0, l_cur};
  end

  // NOTE: every variable assigned in always_comb gets an unconditional
  // default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    next_i = lin_sum;
    if (l_cur != '0) begin
      next_i = circ_sum[DMA_SIZE-1:0];
      if (!mv_neg && (circ_sum >= circ_top)) begin
        // Stepped past the end of the buffer: fold back by one length.
        next_i = circ_sum[DMA_SIZE-1:0] - l_cur;
      end else if (mv_neg && (circ_sum < {1'b0, b_cur})) begin
        // Stepped below the base: fold forward by one length.
        next_i = circ_sum[DMA_SIZE-1:0] + l_cur;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register read mux
  // ---------------------------------------------------------------------------
  reg_grp_e            rd_grp;
  logic [2:0]          rd_idx;
  addr_t               rd_val;
  logic [DMD_SIZE-1:0] rd_ext;

  always_comb begin
    rd_grp = reg_grp_e'(ps_dg_rd_add[4:3]);
    rd_idx = ps_dg_rd_add[2:0];
    unique case (rd_grp)
      GRP_I:   rd_val = i_reg[rd_idx];
      GRP_M:   rd_val = m_reg[rd_idx];
      GRP_L:   rd_val = l_reg[rd_idx];
      default: rd_val = b_reg[rd_idx];
    endcase
    rd_ext                 = '0;
    rd_ext[DMA_SIZE-1:0]   = rd_val;
  end

  // Only the low DMA_SIZE bits of the bus are ever stored.
  logic unused_bus_bits;
  assign unused_bus_bits = ^bc_dg_dt;

  reg_grp_e   wr_grp;
  logic [2:0] wr_idx;
  addr_t      wr_val;

  assign wr_grp = reg_grp_e'(ps_dg_wrt_add[4:3]);
  assign wr_idx = ps_dg_wrt_add[2:0];
  assign wr_val = bc_dg_dt[DMA_SIZE-1:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. That makes
  // every right-hand side see pre-edge values (so a concurrent read returns
  // the old register), and when two updates target the same element the
  // later statement wins -- the write below deliberately follows the
  // post-modify update so a bus write overrides it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the register file is only 32 words of flops, and the
      // architecture requires every I/M/L/B to read back zero after reset,
      // so it is cleared here rather than left uninitialised like a RAM.
      for (int n = 0; n < 8; n++) begin
        i_reg[n] <= '0;
        m_reg[n] <= '0;
        l_reg[n] <= '0;
        b_reg[n] <= '0;
      end
      dg_dm_add <= '0;
      dg_bc_dt  <= '0;
    end else begin
      if (ps_dg_en) begin
        if (ps_dg_premod) begin
          dg_dm_add <= lin_sum;
        end else begin
          dg_dm_add            <= i_cur;
          i_reg[ps_dg_iadd]    <= next_i;
        end
      end

      if (ps_dg_wrt_en) begin
        unique case (wr_grp)
          GRP_I: i_reg[wr_idx] <= wr_val;
          GRP_M: m_reg[wr_idx] <= wr_val;
          GRP_L: l_reg[wr_idx] <= wr_val;
          default: begin
            // Loading a base also restarts the index at the buffer start.
            b_reg[wr_idx] <= wr_val;
            i_reg[wr_idx] <= wr_val;
          end
        endcase
      end

      if (ps_dg_rd_en) begin
        dg_bc_dt <= rd_ext;
      end
    end
  end

endmodule
